// File: rtl/beam_scan_ctrl_pkg.sv
// Shared definitions for the beam scan controller: default parameters,
// FSM state type and energy/accumulator width helpers.
// Optional build macro: SQUARE_ENERGY_EN (squared-sample energy instead of |x|).
package beam_scan_pkg;

    localparam int DEF_DATA_W         = 22;
    localparam int DEF_SEL_W          = 5;
    localparam int DEF_NUM_BEAMS      = 32;
    localparam int DEF_WIN_LOG2       = 10;
    localparam int DEF_SETTLE_SAMPLES = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        ACCUM   = 3'd2,
        COMPARE = 3'd3,
        FINISH  = 3'd4
    } state_e;

    // Width of one energy term. |x| of a DATA_W signed value fits DATA_W
    // unsigned bits; x^2 peaks at 2^(2*DATA_W-2), which fits 2*DATA_W-1 bits.
    function automatic int energy_w(input int data_w);
`ifdef SQUARE_ENERGY_EN
        return 2 * data_w - 1;
`else
        return data_w;
`endif
    endfunction

    // A window of 2^win_log2 terms can never overflow this width.
    function automatic int acc_w(input int data_w, input int win_log2);
        return energy_w(data_w) + win_log2;
    endfunction

endpackage

// File: rtl/beam_scan_ctrl_if.sv
// Signal bundle between the beam scan controller and its surroundings:
// frame clock and beamformed sample in, sweep control, steering and results out.
interface beam_scan_ctrl_if
    import beam_scan_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int ACC_W  = acc_w(DEF_DATA_W, DEF_WIN_LOG2)
);
    logic                     lr_clk;
    logic signed [DATA_W-1:0] sample_in;
    logic                     scan_start;
    logic                     scan_abort;
    logic [SEL_W-1:0]         delay_select;
    logic [SEL_W-1:0]         best_beam;
    logic [ACC_W-1:0]         best_energy;
    logic                     busy;
    logic                     done;

    // Environment side: supplies samples and sweep requests.
    modport master (
        output lr_clk, sample_in, scan_start, scan_abort,
        input  delay_select, best_beam, best_energy, busy, done
    );

    // Controller side.
    modport slave (
        input  lr_clk, sample_in, scan_start, scan_abort,
        output delay_select, best_beam, best_energy, busy, done
    );
endinterface

// File: rtl/beam_scan_ctrl_lr_strobe_sync.sv
// Brings the asynchronous frame clock into the clk domain and turns each
// rising edge into a single-cycle sample strobe.
module lr_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic lr_clk,
    output logic strobe
);
    logic sync1;
    logic sync2;
    logic sync2_prev;

    // Two-flop synchroniser followed by an edge-history flop.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync2_prev <= 1'b0;
        end else begin
            sync1      <= lr_clk;
            sync2      <= sync1;
            sync2_prev <= sync2;
        end
    end

    assign strobe = sync2 & ~sync2_prev;
endmodule

// File: rtl/beam_scan_ctrl.sv
// Closed-loop beam steering controller. Sweeps every steering index, sums
// the energy of the beamformed output over a fixed window per index, then
// parks delay_select on the loudest beam.
// Optional build macro: SQUARE_ENERGY_EN selects squared-sample energy with a
// registered multiplier; otherwise |sample| is used and no multiplier exists.
module beam_scan_ctrl
    import beam_scan_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SEL_W          = DEF_SEL_W,
    parameter int NUM_BEAMS      = DEF_NUM_BEAMS,
    parameter int WIN_LOG2       = DEF_WIN_LOG2,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES
) (
    input  logic              clk,
    input  logic              rst,
    beam_scan_ctrl_if.slave   bus
);
    localparam int E_W   = energy_w(DATA_W);
    localparam int ACC_W = acc_w(DATA_W, WIN_LOG2);
    localparam int SC_W  = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;

    localparam logic [SEL_W-1:0] LAST_BEAM   = SEL_W'(NUM_BEAMS - 1);
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_SAMPLES - 1);

    state_e                   state;
    logic [SEL_W-1:0]         beam_idx;
    logic [SEL_W-1:0]         cand;
    logic [SEL_W-1:0]         best_beam;
    logic [SC_W-1:0]          settle_cnt;
    logic [WIN_LOG2:0]        win_cnt;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         best_acc;
    logic [ACC_W-1:0]         best_energy;
    logic                     done;

    logic                     strobe;
    logic                     smp_vld;
    logic signed [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0]        mag;
    logic [E_W-1:0]           term;
    logic                     win_full;
    logic                     accept;
    logic                     add_en;
    logic                     pend;

    lr_strobe_sync u_strobe (
        .clk    (clk),
        .rst    (rst),
        .lr_clk (bus.lr_clk),
        .strobe (strobe)
    );

    // Capture the sample on its strobe; smp_vld marks the cycle it is usable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q <= '0;
            smp_vld  <= 1'b0;
        end else begin
            smp_vld <= strobe;
            if (strobe) sample_q <= bus.sample_in;
        end
    end

    // Magnitude; the most negative code maps to 2^(DATA_W-1) as unsigned.
    // NOTE: every always_comb output gets a value on every path so no latch
    // is inferred.
    always_comb begin
        mag = $unsigned(sample_q);
        if (sample_q[DATA_W-1]) mag = $unsigned(-sample_q);
    end

    assign win_full = win_cnt[WIN_LOG2];
    assign accept   = (state == ACCUM) && smp_vld && !win_full;

`ifdef SQUARE_ENERGY_EN
    logic [E_W-1:0] sq;
    logic [E_W-1:0] term_q;
    logic           accept_q;

    // Square of the magnitude; the peak value fits E_W bits exactly.
    always_comb sq = E_W'(mag) * E_W'(mag);

    // Register the product so the adder sees it one cycle after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            term_q   <= '0;
            accept_q <= 1'b0;
        end else begin
            accept_q <= accept;
            if (accept) term_q <= sq;
        end
    end

    assign term   = term_q;
    assign add_en = accept_q;
    assign pend   = accept_q;
`else
    assign term   = mag;
    assign add_en = accept;
    assign pend   = 1'b0;
`endif

    // Sweep sequencer, window accumulator and best-beam tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beam_idx    <= '0;
            cand        <= '0;
            best_beam   <= '0;
            settle_cnt  <= '0;
            win_cnt     <= '0;
            acc         <= '0;
            best_acc    <= '0;
            best_energy <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (add_en) acc <= acc + ACC_W'(term);

            if (state != IDLE && bus.scan_abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.scan_start) begin
                            beam_idx   <= '0;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        // Delay line is refilling; these samples are discarded.
                        if (smp_vld) begin
                            if (settle_cnt == SETTLE_LAST) begin
                                settle_cnt <= '0;
                                win_cnt    <= '0;
                                acc        <= '0;
                                state      <= ACCUM;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end
                    end
                    ACCUM: begin
                        if (accept) win_cnt <= win_cnt + 1'b1;
                        // Leave only once the last term has landed in acc.
                        if (win_full && !pend) state <= COMPARE;
                    end
                    COMPARE: begin
                        // Strictly greater keeps the lower index on ties.
                        if (beam_idx == '0 || acc > best_acc) begin
                            best_acc <= acc;
                            cand     <= beam_idx;
                        end
                        if (beam_idx == LAST_BEAM) begin
                            state <= FINISH;
                        end else begin
                            beam_idx   <= beam_idx + 1'b1;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end
                    FINISH: begin
                        best_beam   <= cand;
                        best_energy <= best_acc;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.delay_select = (state == IDLE) ? best_beam : beam_idx;
    assign bus.best_beam    = best_beam;
    assign bus.best_energy  = best_energy;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = done;
endmodule
